// File: rtl/dpic_mem_pkg.sv
// Shared types and default widths for the DPI-C memory arbiter.
// The arbiter and its grant picker import this package.
package dpic_mem_pkg;

    localparam int DEF_ADDR_W = 64;
    localparam int DEF_DATA_W = 64;
    localparam int DEF_MASK_W = DEF_DATA_W / 8;
    localparam int CNT_W      = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } state_e;

    typedef enum logic {
        GNT_IF,
        GNT_LSU
    } grant_e;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] addr;
        logic                  wen;
        logic [DEF_DATA_W-1:0] wdata;
        logic [DEF_MASK_W-1:0] wmask;
    } request_t;

    // The DPI-C memory works on whole 8-byte words.
    function automatic logic [DEF_ADDR_W-1:0] alignAddr(input logic [DEF_ADDR_W-1:0] a);
        return {a[DEF_ADDR_W-1:3], 3'b000};
    endfunction

endpackage

// File: rtl/dpic_mem_rr_picker.sv
// Two-way grant select between IF and LSU. With ARB_ROUND_ROBIN_EN defined, ties go to
// the requester not granted last; otherwise LSU always wins and no pointer is kept.
module dpic_mem_rr_picker
    import dpic_mem_pkg::*;
(
`ifdef ARB_ROUND_ROBIN_EN
    input  logic   clock,
    input  logic   reset,
    input  logic   accept_i,
`endif
    input  logic   if_valid_i,
    input  logic   lsu_valid_i,
    output logic   gnt_valid_o,
    output grant_e gnt_o
);

`ifdef ARB_ROUND_ROBIN_EN
    grant_e last_q;
    grant_e last_d;

    // Reset pointer at IF so the very first tie is won by LSU.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_q <= GNT_IF;
        end else begin
            last_q <= last_d;
        end
    end

    always_comb begin
        last_d = accept_i ? gnt_o : last_q;
    end

    always_comb begin
        gnt_valid_o = if_valid_i | lsu_valid_i;
        gnt_o       = GNT_IF;
        if (if_valid_i && lsu_valid_i) begin
            gnt_o = (last_q == GNT_IF) ? GNT_LSU : GNT_IF;
        end else if (lsu_valid_i) begin
            gnt_o = GNT_LSU;
        end
    end
`else
    always_comb begin
        gnt_valid_o = if_valid_i | lsu_valid_i;
        gnt_o       = lsu_valid_i ? GNT_LSU : GNT_IF;
    end
`endif

endmodule

// File: rtl/dpic_mem_arbiter.sv
// Shares the DPI-C memory port between IF and LSU, one transaction at a time, with
// WAIT_CYCLES wait states. Optional round-robin ties via ARB_ROUND_ROBIN_EN.
module dpic_mem_arbiter
    import dpic_mem_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [ADDR_W-1:0]   if_req_addr,
    output logic                if_resp_valid,
    input  logic                if_resp_ready,
    output logic [DATA_W-1:0]   if_resp_data,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_req_addr,
    input  logic                lsu_req_wen,
    input  logic [DATA_W-1:0]   lsu_req_wdata,
    input  logic [DATA_W/8-1:0] lsu_req_wmask,
    output logic                lsu_resp_valid,
    input  logic                lsu_resp_ready,
    output logic [DATA_W-1:0]   lsu_resp_data,
    output logic [ADDR_W-1:0]   mem_raddr,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [ADDR_W-1:0]   mem_waddr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    request_t          req_q, req_d;
    grant_e            gnt_q, gnt_d;
    logic [DATA_W-1:0] resp_q, resp_d;

    grant_e            pick;
    logic              pick_valid;
    logic              accept;
    logic              resp_ready_sel;
    logic              resp_valid_any;
    logic [DATA_W-1:0] access_data;
    logic [DATA_W-1:0] resp_data_now;

    dpic_mem_rr_picker u_picker (
`ifdef ARB_ROUND_ROBIN_EN
        .clock       (clock),
        .reset       (reset),
        .accept_i    (accept),
`endif
        .if_valid_i  (if_req_valid),
        .lsu_valid_i (lsu_req_valid),
        .gnt_valid_o (pick_valid),
        .gnt_o       (pick)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            gnt_q   <= GNT_IF;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            gnt_q   <= gnt_d;
            resp_q  <= resp_d;
        end
    end

    assign resp_ready_sel = (gnt_q == GNT_LSU) ? lsu_resp_ready : if_resp_ready;
    assign access_data    = req_q.wen ? '0 : mem_rdata;

    // The response is offered already in the ACCESS cycle so that accept-to-valid latency
    // is WAIT_CYCLES+1; a handshake there skips RESP entirely.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        gnt_d   = gnt_q;
        resp_d  = resp_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    accept  = 1'b1;
                    gnt_d   = pick;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
                    if (pick == GNT_LSU) begin
                        req_d.addr  = alignAddr(lsu_req_addr);
                        req_d.wen   = lsu_req_wen;
                        req_d.wdata = lsu_req_wdata;
                        req_d.wmask = lsu_req_wmask;
                    end else begin
                        req_d.addr  = alignAddr(if_req_addr);
                        req_d.wen   = 1'b0;
                        req_d.wdata = '0;
                        req_d.wmask = '0;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                resp_d  = access_data;
                state_d = resp_ready_sel ? IDLE : RESP;
            end
            RESP: begin
                if (resp_ready_sel) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign if_req_ready   = accept && (pick == GNT_IF);
    assign lsu_req_ready  = accept && (pick == GNT_LSU);

    assign resp_valid_any = (state_q == ACCESS) || (state_q == RESP);
    assign resp_data_now  = (state_q == ACCESS) ? access_data : resp_q;

    assign if_resp_valid  = resp_valid_any && (gnt_q == GNT_IF);
    assign lsu_resp_valid = resp_valid_any && (gnt_q == GNT_LSU);
    assign if_resp_data   = if_resp_valid ? resp_data_now : '0;
    assign lsu_resp_data  = lsu_resp_valid ? resp_data_now : '0;

    assign mem_raddr = req_q.addr;
    assign mem_waddr = req_q.addr;
    assign mem_wdata = req_q.wdata;
    assign mem_wmask = ((state_q == ACCESS) && req_q.wen) ? req_q.wmask : '0;

endmodule
